// File: rtl/pipelined_add_sub.sv
// Pipelined two's-complement add/sub: carry chain cut into STAGES chunks, one register rank per chunk.
// Latency: STAGES cycles from input accept to out_valid (plus any stall cycles).
// Backpressure: whole pipe advances only when output is empty or being drained; in_ready mirrors that.
module pipelined_add_sub #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    localparam int CW   = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    // Rank k holds the bundle that stage k operates on. Operands are kept full
    // width so their sign bits travel with the bundle for the overflow check.
    logic             vld_q [STAGES];
    logic [WIDTH-1:0] a_q   [STAGES];
    logic [WIDTH-1:0] b_q   [STAGES];
    logic [WIDTH-1:0] s_q   [STAGES];
    logic             c_q   [STAGES];

    logic [CW:0]      chunk  [STAGES];
    logic [WIDTH-1:0] st_sum [STAGES];
    logic             st_c   [STAGES];
    logic             ovf_nxt;
    logic             adv;

    // The pipeline moves as a whole: either the output slot is empty or it is leaving.
    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    // Stage k adds chunk k plus the carry left by stage k-1 and merges it into the partial sum.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            chunk[k]  = {1'b0, a_q[k][k*CW +: CW]} + {1'b0, b_q[k][k*CW +: CW]}
                      + {{CW{1'b0}}, c_q[k]};
            st_sum[k] = s_q[k];
            st_sum[k][k*CW +: CW] = chunk[k][CW-1:0];
            st_c[k]   = chunk[k][CW];
        end
        ovf_nxt = (a_q[LAST][WIDTH-1] == b_q[LAST][WIDTH-1])
                & (st_sum[LAST][WIDTH-1] != a_q[LAST][WIDTH-1]);
    end

    // Capture prepared operands, shift every rank forward, and register the final result.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_q[k] <= 1'b0;
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                s_q[k]   <= '0;
                c_q[k]   <= 1'b0;
            end
            out_valid <= 1'b0;
            sum       <= '0;
            c_out     <= 1'b0;
            ovf       <= 1'b0;
        end else if (adv) begin
            // Subtraction is a + ~b + 1, so cin is replaced by the forced 1.
            vld_q[0] <= in_valid;
            a_q[0]   <= a;
            b_q[0]   <= sub ? ~b : b;
            s_q[0]   <= '0;
            c_q[0]   <= sub ? 1'b1 : cin;
            for (int k = 1; k < STAGES; k++) begin
                vld_q[k] <= vld_q[k-1];
                a_q[k]   <= a_q[k-1];
                b_q[k]   <= b_q[k-1];
                s_q[k]   <= st_sum[k-1];
                c_q[k]   <= st_c[k-1];
            end
            out_valid <= vld_q[LAST];
            sum       <= st_sum[LAST];
            c_out     <= st_c[LAST];
            ovf       <= ovf_nxt;
        end
    end

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Directed bench for pipelined_add_sub (WIDTH=16, STAGES=4).
// Vector table for arithmetic + latency, then stall, bubble and mid-flight reset sequences.
// Inputs change 1 time unit after the rising edge; pipeline outputs are read at the falling edge.
module tb_pipelined_add_sub;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        c_out;
    logic        ovf;

    int n_tests = 0;
    int n_fail  = 0;

    pipelined_add_sub #(.WIDTH(16), .STAGES(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] s;
        logic        c;
        logic        v;
    } vec_t;

    vec_t vt[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer arithmetic; overflow from the signed result range.
    function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                          input logic ci, input logic sb);
        logic [16:0] r;
        int          sr;
        logic        v;
        r  = {1'b0, x} + {1'b0, (sb ? ~y : y)} + (sb ? 17'd1 : {16'd0, ci});
        sr = sb ? ($signed(x) - $signed(y)) : ($signed(x) + $signed(y) + int'(ci));
        v  = (sr > 32767) || (sr < -32768);
        return {v, r};
    endfunction

    // One isolated bundle: checks latency and the three result fields.
    task automatic run_vec(input vec_t v, input string nm);
        int n;
        a = v.a; b = v.b; cin = v.cin; sub = v.sub;
        in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        chk({nm, " latency"}, n, 4);
        chk({nm, " sum"}, sum, v.s);
        chk({nm, " c_out"}, c_out, v.c);
        chk({nm, " ovf"}, ovf, v.v);
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [17:0] exp_q[$];
        logic [17:0] e;
        logic [15:0] sa[8];
        logic [15:0] sbv[8];
        logic        ssub[8];
        logic        scin[8];
        logic        iv[16];
        logic [15:0] prev_sum;
        logic        prev_stall;
        int          idx;
        int          got;

        vt[0] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
        vt[1] = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
        vt[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vt[3] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vt[4] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vt[5] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
        vt[6] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vt[7] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
        vt[8] = '{16'h0F0F, 16'h00F1, 1'b1, 1'b0, 16'h1001, 1'b0, 1'b0};
        vt[9] = '{16'h7FFF, 16'hFFFF, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1};

        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        chk("reset out_valid", out_valid, 0);
        chk("reset sum", sum, 0);
        chk("reset c_out", c_out, 0);
        chk("reset ovf", ovf, 0);
        chk("reset in_ready", in_ready, 1);

        for (int i = 0; i < 10; i++) run_vec(vt[i], $sformatf("vec%0d", i));

        // Back-to-back stream with the output stalled in cycles 5..7.
        for (int i = 0; i < 8; i++) begin
            sa[i]   = 16'($urandom);
            sbv[i]  = 16'($urandom);
            ssub[i] = 1'($urandom_range(0, 1));
            scin[i] = 1'($urandom_range(0, 1));
        end
        idx = 0; got = 0; prev_stall = 1'b0; prev_sum = '0;
        for (int c = 0; c < 25; c++) begin
            out_ready = !(c >= 5 && c <= 7);
            in_valid  = (idx < 8);
            if (idx < 8) begin
                a = sa[idx]; b = sbv[idx]; sub = ssub[idx]; cin = scin[idx];
            end
            @(negedge clk);
            chk($sformatf("stall in_ready c%0d", c), in_ready, !(c >= 5 && c <= 7));
            if (prev_stall) begin
                chk($sformatf("stall hold valid c%0d", c), out_valid, 1);
                chk($sformatf("stall hold sum c%0d", c), sum, prev_sum);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("stall unexpected result", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("stream%0d sum", got), sum, e[15:0]);
                    chk($sformatf("stream%0d c_out", got), c_out, e[16]);
                    chk($sformatf("stream%0d ovf", got), ovf, e[17]);
                    got++;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_sum   = sum;
            if (in_valid && in_ready) begin
                exp_q.push_back(model(sa[idx], sbv[idx], scin[idx], ssub[idx]));
                idx++;
            end
            step();
        end
        chk("stream result count", got, 8);
        chk("stream accept count", idx, 8);

        // Alternating bubbles: out_valid repeats in_valid five intervals later (4 edges after accept).
        out_ready = 1'b1; sub = 1'b0; cin = 1'b0;
        for (int c = 0; c < 16; c++) begin
            iv[c]    = (c < 8) && (c % 2 == 0);
            in_valid = iv[c];
            a = 16'(c); b = 16'h0100;
            @(negedge clk);
            chk($sformatf("bubble out_valid c%0d", c), out_valid, (c >= 5) ? iv[c-5] : 1'b0);
            if (c >= 5 && iv[c-5]) chk($sformatf("bubble sum c%0d", c), sum, 16'h0100 + 16'(c - 5));
            step();
        end

        // Three bundles in flight, then a one-cycle reset discards them.
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1; a = 16'h1111 * 16'(c + 1); b = 16'h2222; sub = 1'b0; cin = 1'b1;
            step();
        end
        in_valid = 1'b0;
        reset_n  = 1'b0;
        step();
        reset_n = 1'b1;
        chk("midreset out_valid", out_valid, 0);
        chk("midreset sum", sum, 0);
        chk("midreset c_out", c_out, 0);
        chk("midreset ovf", ovf, 0);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk($sformatf("midreset no result c%0d", c), out_valid, 0);
            step();
        end
        run_vec(vt[3], "post reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
